// File: rtl/fp_pkg.sv
// Shared small-float definitions for the FP multiplier and adder stages.
// Packed word layout is {sign, exponent, mantissa}. There are no subnormals:
// exponent 0 with a nonzero mantissa is a normal value with an implicit 1.
package fp_pkg;

   localparam int unsigned EXP_WIDTH      = 4;
   localparam int unsigned MANTISSA_WIDTH = 3;
   localparam int unsigned FP_WIDTH       = EXP_WIDTH + MANTISSA_WIDTH + 1;
   localparam int unsigned SIG_WIDTH      = MANTISSA_WIDTH + 1;
   localparam int unsigned PROD_WIDTH     = 2 * SIG_WIDTH;
   localparam int unsigned EXPS_WIDTH     = EXP_WIDTH + 2;
   localparam int unsigned BIAS           = (1 << (EXP_WIDTH - 1)) - 1;

   localparam logic [EXP_WIDTH-1:0] E_MAX = '1;
   // Exponent/mantissa part of the special word; the sign is supplied separately
   localparam logic [FP_WIDTH-2:0]  SPECIAL_ENC = {E_MAX, MANTISSA_WIDTH'(1)};

   typedef struct packed {
      logic                 sign;
      logic [EXP_WIDTH-1:0] exp;
      logic [SIG_WIDTH-1:0] sig;   // mantissa with the implicit leading 1
   } fp_unpacked_t;

   // Multiplier stage-1 payload
   typedef struct packed {
      logic                  sign;
      logic [EXPS_WIDTH-1:0] exp;    // two's complement ea+eb-bias
      logic [PROD_WIDTH-1:0] prod;   // significand product in [1,4)
      logic                  zero;
      logic                  special;
      logic                  last;
   } fp_mul_s1_t;

   // Zero is the all-zero word; -0 also counts as zero
   function automatic logic fp_is_zero(input logic [FP_WIDTH-1:0] x);
      return (x[FP_WIDTH-2:0] == '0);
   endfunction

   function automatic fp_unpacked_t fp_unpack(input logic [FP_WIDTH-1:0] x);
      fp_unpacked_t u;
      u.sign = x[FP_WIDTH-1];
      u.exp  = x[FP_WIDTH-2 -: EXP_WIDTH];
      u.sig  = {1'b1, x[MANTISSA_WIDTH-1:0]};
      return u;
   endfunction

endpackage

// File: rtl/fp_mul_norm_round.sv
// Combinational second stage of the FP multiplier: normalize, round to
// nearest (ties away), saturate to the special word or flush to zero, pack.
// Ports:
//   sign_i     product sign
//   exp_i      two's complement exponent sum (ea+eb-bias)
//   prod_i     significand product, value in [1,4)
//   zero_i     an operand was zero
//   special_i  an operand had the all-ones exponent
//   p_o        packed product
//   special_o  p_o is the special encoding
module fp_mul_norm_round
   import fp_pkg::*;
(
   input  logic                  sign_i,
   input  logic [EXPS_WIDTH-1:0] exp_i,
   input  logic [PROD_WIDTH-1:0] prod_i,
   input  logic                  zero_i,
   input  logic                  special_i,
   output logic [FP_WIDTH-1:0]   p_o,
   output logic                  special_o
);

   localparam int unsigned LO_MSB = PROD_WIDTH - MANTISSA_WIDTH - 4;

   logic signed [EXPS_WIDTH-1:0] exp_norm;
   logic signed [EXPS_WIDTH-1:0] exp_fin;
   logic [MANTISSA_WIDTH-1:0]    mant_norm;
   logic [MANTISSA_WIDTH-1:0]    mant_fin;
   logic                         round_bit;
   logic                         carry;
   logic                         prod_lo_unused;

   // Bits below the rounding position never influence the result
   assign prod_lo_unused = ^prod_i[LO_MSB:0];

   // Normalize so the leading 1 sits just above the kept mantissa bits
   always_comb begin
      exp_norm  = $signed(exp_i);
      mant_norm = prod_i[PROD_WIDTH-3 -: MANTISSA_WIDTH];
      round_bit = prod_i[PROD_WIDTH-3-MANTISSA_WIDTH];
      if (prod_i[PROD_WIDTH-1]) begin
         exp_norm  = $signed(exp_i) + $signed(EXPS_WIDTH'(1));
         mant_norm = prod_i[PROD_WIDTH-2 -: MANTISSA_WIDTH];
         round_bit = prod_i[PROD_WIDTH-2-MANTISSA_WIDTH];
      end
   end

   // Carry out of the stored mantissa equals carry out of the full significand
   always_comb begin
      {carry, mant_fin} = (MANTISSA_WIDTH+1)'(mant_norm) + (MANTISSA_WIDTH+1)'(round_bit);
      exp_fin           = exp_norm;
      if (carry) begin
         mant_fin = '0;
         exp_fin  = exp_norm + $signed(EXPS_WIDTH'(1));
      end
   end

   // Special input wins over zero input; then overflow, then underflow flush
   always_comb begin
      p_o       = '0;
      special_o = 1'b0;
      if (special_i) begin
         p_o       = {sign_i, SPECIAL_ENC};
         special_o = 1'b1;
      end else if (zero_i) begin
         p_o = '0;
      end else if (exp_fin >= $signed(EXPS_WIDTH'(E_MAX))) begin
         p_o       = {sign_i, SPECIAL_ENC};
         special_o = 1'b1;
      end else if (exp_fin < $signed(EXPS_WIDTH'(1))) begin
         p_o = '0;
      end else begin
         p_o = {sign_i, exp_fin[EXP_WIDTH-1:0], mant_fin};
      end
   end

endmodule

// File: rtl/fp_mul_pipe.sv
// Two-stage pipelined small-float multiplier with valid/ready on both sides.
// S1 registers sign, exponent sum, significand product and zero/special flags;
// S2 registers the normalized, rounded, packed product.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready operand handshake; in_ready depends on out_ready
//   in_a, in_b        packed operands {s, e, m}
//   in_last           sideband carried with the pair
//   out_valid/out_ready product handshake
//   out_p             packed product
//   out_last          in_last of the same pair
//   out_special       out_p is the special encoding
module fp_mul_pipe
   import fp_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [FP_WIDTH-1:0] in_a,
   input  logic [FP_WIDTH-1:0] in_b,
   input  logic                in_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [FP_WIDTH-1:0] out_p,
   output logic                out_last,
   output logic                out_special
);

   fp_unpacked_t        ua;
   fp_unpacked_t        ub;
   fp_mul_s1_t          s1_d;
   fp_mul_s1_t          s1_q;
   logic                s1_valid_q;
   logic                s2_valid_q;
   logic                s1_ready;
   logic                s2_ready;
   logic [FP_WIDTH-1:0] p_d;
   logic                special_d;
   logic [FP_WIDTH-1:0] out_p_q;
   logic                out_last_q;
   logic                out_special_q;

   // Each stage accepts when empty or when its downstream is draining
   assign s2_ready = ~s2_valid_q | out_ready;
   assign s1_ready = ~s1_valid_q | s2_ready;
   assign in_ready = s1_ready;

   // Stage-1 datapath
   always_comb begin
      ua           = fp_unpack(in_a);
      ub           = fp_unpack(in_b);
      s1_d         = '0;
      s1_d.sign    = ua.sign ^ ub.sign;
      s1_d.exp     = EXPS_WIDTH'(ua.exp) + EXPS_WIDTH'(ub.exp) - EXPS_WIDTH'(BIAS);
      s1_d.prod    = PROD_WIDTH'(ua.sig) * PROD_WIDTH'(ub.sig);
      s1_d.zero    = fp_is_zero(in_a) | fp_is_zero(in_b);
      s1_d.special = (ua.exp == E_MAX) | (ub.exp == E_MAX);
      s1_d.last    = in_last;
   end

   // Stage-1 register
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_q       <= '0;
      end else if (s1_ready) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_q <= s1_d;
         end
      end
   end

   fp_mul_norm_round u_norm_round (
      .sign_i    (s1_q.sign),
      .exp_i     (s1_q.exp),
      .prod_i    (s1_q.prod),
      .zero_i    (s1_q.zero),
      .special_i (s1_q.special),
      .p_o       (p_d),
      .special_o (special_d)
   );

   // Stage-2 register; holds its data while stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_q    <= 1'b0;
         out_p_q       <= '0;
         out_last_q    <= 1'b0;
         out_special_q <= 1'b0;
      end else if (s2_ready) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            out_p_q       <= p_d;
            out_last_q    <= s1_q.last;
            out_special_q <= special_d;
         end
      end
   end

   assign out_valid   = s2_valid_q;
   assign out_p       = out_p_q;
   assign out_last    = out_last_q;
   assign out_special = out_special_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: directed vector table, backpressure and mid-stream
// reset sequences, and a random stream against a real-arithmetic model.
module tb_fp_mul_pipe;
   import fp_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_p;
   logic       out_last;
   logic       out_special;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] p;
      logic       sp;
      string      name;
   } vec_t;

   vec_t vecs[$];

   fp_mul_pipe dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_last     (in_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_p       (out_p),
      .out_last    (out_last),
      .out_special (out_special)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Golden product {special, p} computed with real arithmetic
   function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b);
      int  ea, eb, ma, mb, e, m;
      real v;
      logic s;
      s  = a[7] ^ b[7];
      ea = int'(a[6:3]);
      eb = int'(b[6:3]);
      ma = int'(a[2:0]);
      mb = int'(b[2:0]);
      if (ea == 15 || eb == 15) return {1'b1, s, 4'hF, 3'd1};
      if (a[6:0] == 7'd0 || b[6:0] == 7'd0) return 9'h000;
      v = (1.0 + ma / 8.0) * (1.0 + mb / 8.0);
      e = ea + eb - 7;
      while (v >= 2.0) begin
         v = v / 2.0;
         e++;
      end
      m = $rtoi((v - 1.0) * 8.0 + 0.5);
      if (m == 8) begin
         m = 0;
         e++;
      end
      if (e >= 15) return {1'b1, s, 4'hF, 3'd1};
      if (e < 1) return 9'h000;
      return {1'b0, s, 4'(e), 3'(m)};
   endfunction

   function automatic void add_vec(input logic [7:0] a, input logic [7:0] b,
                                   input logic [7:0] p, input logic sp, input string name);
      vec_t v;
      v.a = a; v.b = b; v.p = p; v.sp = sp; v.name = name;
      vecs.push_back(v);
   endfunction

   // One pair into an empty pipe with out_ready=1; checks 2-cycle latency and result
   task automatic single_vec(input logic [7:0] a, input logic [7:0] b, input logic [7:0] p,
                             input logic sp, input logic last, input string name);
      logic v1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      in_last   = last;
      @(posedge clk); #1;
      in_valid = 1'b0;
      v1       = out_valid;
      @(posedge clk); #1;
      chk({name, "_lat"}, 32'({v1, out_valid}), 32'(2'b01));
      chk({name, "_p"}, 32'(out_p), 32'(p));
      chk({name, "_sp"}, 32'(out_special), 32'(sp));
      chk({name, "_last"}, 32'(out_last), 32'(last));
      @(posedge clk); #1;
   endtask

   task automatic gen_pair(input bit rnd, input int idx);
      if (rnd) begin
         in_a = 8'($urandom);
         in_b = 8'($urandom);
      end else begin
         in_a = 8'h38 + 8'(idx);
         in_b = 8'hC1 - 8'(idx);
      end
   endtask

   // Streams n pairs; rnd=0 is the directed backpressure pattern
   task automatic run_stream(input int n, input bit rnd, input string tag);
      int         sent = 0;
      int         got  = 0;
      int         cyc  = 0;
      int         limit;
      logic [9:0] expq[$];
      logic [9:0] e;
      logic       prev_stall = 1'b0;
      logic [7:0] prev_p     = 8'h00;
      logic       acc;
      logic       emit;
      limit     = n * 4 + 50;
      in_valid  = 1'b1;
      gen_pair(rnd, 0);
      in_last   = (n == 1);
      out_ready = rnd ? 1'($urandom_range(1)) : 1'b0;
      while (got < n && cyc < limit) begin
         @(negedge clk);
         acc  = in_valid & in_ready;
         emit = out_valid & out_ready;
         if (!rnd && cyc == 2) begin
            chk({tag, "_accepts_at_stall"}, 32'(sent), 32'd2);
            chk({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
         end
         if (!rnd && cyc == 4) chk({tag, "_in_ready_rise"}, 32'(in_ready), 32'd1);
         if (prev_stall) chk({tag, "_stall_hold"}, 32'({out_valid, out_p}), 32'({1'b1, prev_p}));
         prev_stall = out_valid & ~out_ready;
         prev_p     = out_p;
         if (emit) begin
            if (expq.size() == 0) begin
               chk({tag, "_spurious"}, 32'(out_p), 32'hFFFF_FFFF);
            end else begin
               e = expq.pop_front();
               chk({tag, "_out"}, 32'({out_last, out_special, out_p}), 32'(e));
            end
            got++;
         end
         if (acc) begin
            expq.push_back({in_last, model(in_a, in_b)});
            sent++;
         end
         @(posedge clk); #1;
         cyc++;
         if (acc) in_valid = 1'b0;
         if (!in_valid && sent < n && (!rnd || $urandom_range(3) != 0)) begin
            in_valid = 1'b1;
            gen_pair(rnd, sent);
            in_last = (sent == n - 1);
         end
         out_ready = rnd ? 1'($urandom_range(1)) : (cyc >= 4);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk({tag, "_count"}, 32'(got), 32'(n));
      chk({tag, "_drained"}, 32'(expq.size()), 32'd0);
   endtask

   initial begin
      int stale;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = 8'h00;
      in_b      = 8'h00;
      in_last   = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      chk("reset_outputs", 32'({out_valid, out_p, out_last, out_special}), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);

      // Hand-computed products
      add_vec(8'h3C, 8'h3C, 8'h41, 1'b0, "mul_1p5_1p5");
      add_vec(8'hC0, 8'h3C, 8'hC4, 1'b0, "mul_neg2_1p5");
      add_vec(8'h39, 8'h39, 8'h3A, 1'b0, "round_down");
      add_vec(8'h39, 8'h3D, 8'h3F, 1'b0, "round_up");
      add_vec(8'h3F, 8'h3F, 8'h46, 1'b0, "renorm");        // 1.875^2=3.516 -> 2*1.75
      add_vec(8'h39, 8'h3E, 8'h40, 1'b0, "round_carry");   // 1.96875 -> 2.0
      add_vec(8'hB9, 8'h3E, 8'hC0, 1'b0, "neg_round_carry");
      add_vec(8'h6F, 8'h3F, 8'h76, 1'b0, "max_normal");
      add_vec(8'h70, 8'h40, 8'h79, 1'b1, "overflow");
      add_vec(8'h71, 8'h3E, 8'h79, 1'b1, "round_overflow");
      add_vec(8'h08, 8'h08, 8'h00, 1'b0, "underflow");
      add_vec(8'h10, 8'h28, 8'h00, 1'b0, "exp0_flush");
      add_vec(8'h08, 8'h38, 8'h08, 1'b0, "exp1_kept");
      add_vec(8'h38, 8'h00, 8'h00, 1'b0, "zero_in");
      add_vec(8'h80, 8'h3C, 8'h00, 1'b0, "neg_zero_in");
      add_vec(8'h78, 8'h38, 8'h79, 1'b1, "special_in");
      add_vec(8'h78, 8'h00, 8'h79, 1'b1, "special_beats_zero");
      add_vec(8'hF8, 8'h38, 8'hF9, 1'b1, "neg_special");

      for (int i = 0; i < vecs.size(); i++) begin
         single_vec(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].sp, 1'(i % 2), vecs[i].name);
      end

      run_stream(6, 1'b0, "bp");

      // Mid-stream reset with both stages full
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_a      = 8'h3C;
      in_b      = 8'h3C;
      in_last   = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_pre_full", 32'({out_valid, in_ready}), 32'(2'b10));
      rst      = 1'b1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      chk("rst_flush", 32'({out_valid, in_ready, out_p, out_last, out_special}), 32'({1'b0, 1'b1, 10'd0}));
      stale = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (out_valid) stale++;
      end
      chk("rst_no_stale", 32'(stale), 32'd0);
      single_vec(8'hC0, 8'h3C, 8'hC4, 1'b0, 1'b1, "post_rst");

      run_stream(10000, 1'b1, "rand");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
